// File: rtl/user_test_pattern_pkg.sv
// Shared types and helpers for the user test pattern generator.
// Used by user_test_pattern_bank and user_test_pattern_gen.
package user_test_pattern_pkg;

  typedef enum logic [1:0] {
    TP_IDLE,
    TP_RUN,
    TP_DONE
  } tp_state_e;

  localparam int PAT_REG_W = 16;

  localparam logic TP_MODE_CONT   = 1'b0;
  localparam logic TP_MODE_SINGLE = 1'b1;

  // Zero means one pattern; anything past the bank size means all of it.
  function automatic int clamp_count(
    input int raw,
    input int numPat
  );
    if (raw < 1) return 1;
    if (raw > numPat) return numPat;
    return raw;
  endfunction

endpackage

// File: rtl/user_test_pattern_bank.sv
// Shadow bank of user patterns with clamped count and MSB-justified
// read ports; a load in progress is forwarded to the read side.
module user_test_pattern_bank
  import user_test_pattern_pkg::*;
#(
  parameter int DATA_W  = 14,
  parameter int NUM_PAT = 4,
  parameter int NUM_RD  = 2,
  parameter int IW      = 2,
  parameter int CW      = 3
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         load,
  input  logic [NUM_PAT*PAT_REG_W-1:0] patIn,
  input  logic [CW-1:0]                numIn,
  input  logic [NUM_RD*IW-1:0]         rdIdx,
  output logic [CW-1:0]                count,
  output logic [NUM_RD*DATA_W-1:0]     rdData
);

  logic [PAT_REG_W-1:0] shadow [NUM_PAT];
  logic [PAT_REG_W-1:0] effPat [NUM_PAT];
  logic [CW-1:0]        countQ;
  logic [CW-1:0]        numClamped;

  assign numClamped = CW'(clamp_count(int'(numIn), NUM_PAT));

  // Capture the pattern set and its clamped length.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int k = 0; k < NUM_PAT; k++) begin
        shadow[k] <= '0;
      end
      countQ <= CW'(1);
    end else if (load) begin
      for (int k = 0; k < NUM_PAT; k++) begin
        shadow[k] <= patIn[k*PAT_REG_W +: PAT_REG_W];
      end
      countQ <= numClamped;
    end
  end

  // A start on the load edge must already see the new bank.
  always_comb begin
    for (int k = 0; k < NUM_PAT; k++) begin
      effPat[k] = load ? patIn[k*PAT_REG_W +: PAT_REG_W]
                       : shadow[k];
    end
  end

  assign count = load ? numClamped : countQ;

  for (genvar r = 0; r < NUM_RD; r++) begin : gRd
    logic [IW-1:0]        idx;
    logic [PAT_REG_W-1:0] word;
    logic                 unusedLsb;

    assign idx  = rdIdx[r*IW +: IW];
    assign word = (int'(idx) < NUM_PAT) ? effPat[idx] : '0;
    assign rdData[r*DATA_W +: DATA_W] =
      word[PAT_REG_W-1 -: DATA_W];
    assign unusedLsb = ^word;
  end

endmodule

// File: rtl/user_test_pattern_gen.sv
// User test pattern generator: replays the shadow bank on all channels.
// USER_TP_CH_STAGGER_EN offsets channel c by c patterns.
module user_test_pattern_gen
  import user_test_pattern_pkg::*;
#(
  parameter int DATA_W  = 14,
  parameter int NUM_PAT = 4,
  parameter int NUM_CH  = 2
) (
  input  logic                                in_clk,
  input  logic                                in_rst_n,
  input  logic [NUM_PAT*PAT_REG_W-1:0]        in_Patterns,
  input  logic [$clog2(NUM_PAT+1)-1:0]        in_NumActive,
  input  logic                                in_Load,
  input  logic                                in_Mode,
  input  logic                                in_Enable,
  output logic [NUM_CH*DATA_W-1:0]            out_Data,
  output logic                                out_Valid,
  output logic [((NUM_PAT > 1) ? $clog2(NUM_PAT) : 1)-1:0] out_Index,
  output logic                                out_Done
);

  localparam int CW = $clog2(NUM_PAT + 1);
  localparam int IW = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;

  tp_state_e state, stateN;
  logic [IW-1:0] ptr, ptrN;
  logic          modeQ, modeN;
  logic          validN, doneN;
  logic [IW-1:0] indexN;
  logic [NUM_CH*DATA_W-1:0] dataN;
  logic          takeSample;

  logic [CW-1:0]           count;
  logic [IW-1:0]           rdBase;
  logic [IW-1:0]           walk;
  logic [NUM_CH*IW-1:0]    rdIdx;
  logic [NUM_CH*DATA_W-1:0] rdData;
  logic                    bankLoad;

  function automatic logic [IW-1:0] wrapInc(
    input logic [IW-1:0] p,
    input logic [CW-1:0] cnt
  );
    return (CW'(p) == cnt - CW'(1)) ? '0 : p + IW'(1);
  endfunction

  assign bankLoad = in_Load && (state != TP_RUN);
  assign rdBase   = (state == TP_RUN) ? ptr : '0;

  user_test_pattern_bank #(
    .DATA_W  (DATA_W),
    .NUM_PAT (NUM_PAT),
    .NUM_RD  (NUM_CH),
    .IW      (IW),
    .CW      (CW)
  ) uBank (
    .clk    (in_clk),
    .rstN   (in_rst_n),
    .load   (bankLoad),
    .patIn  (in_Patterns),
    .numIn  (in_NumActive),
    .rdIdx  (rdIdx),
    .count  (count),
    .rdData (rdData)
  );

  // Per-channel read index, optionally walked forward by channel number.
  always_comb begin
    rdIdx = '0;
    walk  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      walk = rdBase;
`ifdef USER_TP_CH_STAGGER_EN
      for (int k = 0; k < c; k++) begin
        walk = wrapInc(walk, count);
      end
`endif
      rdIdx[c*IW +: IW] = walk;
    end
  end

  // Next state, pointer and registered outputs.
  always_comb begin
    stateN     = state;
    ptrN       = ptr;
    modeN      = modeQ;
    validN     = out_Valid;
    indexN     = out_Index;
    doneN      = out_Done;
    takeSample = 1'b0;
    unique case (state)
      TP_IDLE: begin
        if (in_Enable) begin
          stateN     = TP_RUN;
          modeN      = in_Mode;
          takeSample = 1'b1;
          validN     = 1'b1;
          indexN     = '0;
          ptrN       = wrapInc('0, count);
        end
      end
      TP_RUN: begin
        if (!in_Enable) begin
          stateN = TP_IDLE;
          ptrN   = '0;
          validN = 1'b0;
          indexN = '0;
          doneN  = 1'b0;
        end else if (modeQ == TP_MODE_SINGLE && ptr == '0) begin
          stateN = TP_DONE;
          validN = 1'b1;
          doneN  = 1'b1;
          indexN = '0;
        end else begin
          takeSample = 1'b1;
          indexN     = ptr;
          ptrN       = wrapInc(ptr, count);
        end
      end
      TP_DONE: begin
        if (!in_Enable) begin
          stateN = TP_IDLE;
          ptrN   = '0;
          validN = 1'b0;
          indexN = '0;
          doneN  = 1'b0;
        end
      end
      default: begin
        stateN = TP_IDLE;
      end
    endcase
    dataN = takeSample ? rdData : '0;
  end

  // State, pointer and output registers.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state     <= TP_IDLE;
      ptr       <= '0;
      modeQ     <= TP_MODE_CONT;
      out_Data  <= '0;
      out_Valid <= 1'b0;
      out_Index <= '0;
      out_Done  <= 1'b0;
    end else begin
      state     <= stateN;
      ptr       <= ptrN;
      modeQ     <= modeN;
      out_Data  <= dataN;
      out_Valid <= validN;
      out_Index <= indexN;
      out_Done  <= doneN;
    end
  end

endmodule
